// File: rtl/register_bank_dump_reader.sv
// register_bank_dump_reader: streams a wrap-around range of register-bank words out on valid/ready
// Ports:
//   clk, rst (async, active-low)
//   bank_q                        flattened bank, register i at bank_q[DATA_LENGTH*i +: DATA_LENGTH]
//   start, start_addr, last_addr  dump request and inclusive address range, sampled in IDLE
//   abort                         cancels a running dump without done
//   out_valid, out_ready          stream handshake; out_data/out_addr carry one word
//   busy                          dump in progress
//   done                          one-cycle pulse after the final word is accepted
module register_bank_dump_reader #(
   parameter int DATA_LENGTH = 32,
   parameter int REGS_QTY = 32,
   localparam int ADDR_LENGTH = $clog2(REGS_QTY)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [REGS_QTY*DATA_LENGTH-1:0] bank_q,
   input  logic                            start,
   input  logic [ADDR_LENGTH-1:0]          start_addr,
   input  logic [ADDR_LENGTH-1:0]          last_addr,
   input  logic                            abort,
   input  logic                            out_ready,
   output logic                            out_valid,
   output logic [DATA_LENGTH-1:0]          out_data,
   output logic [ADDR_LENGTH-1:0]          out_addr,
   output logic                            busy,
   output logic                            done
);
   typedef enum logic {IDLE, SEND} state_t;
   localparam logic [ADDR_LENGTH:0] QTY = (ADDR_LENGTH+1)'(REGS_QTY);
   localparam logic [ADDR_LENGTH-1:0] TOP = ADDR_LENGTH'(REGS_QTY-1);
   state_t state;
   logic [ADDR_LENGTH-1:0] last;
   logic [DATA_LENGTH-1:0] words [REGS_QTY];
   logic [ADDR_LENGTH-1:0] next;
   logic in_range;
   for (genvar i = 0; i < REGS_QTY; i++) begin : g_w
      assign words[i] = bank_q[DATA_LENGTH*i +: DATA_LENGTH];
   end
   assign next = (out_addr == TOP) ? '0 : out_addr + 1'b1;
   // Out-of-range addresses are only possible when REGS_QTY is not a power of two
   assign in_range = ({1'b0, start_addr} < QTY) && ({1'b0, last_addr} < QTY);
   assign busy = (state == SEND);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         out_valid <= 1'b0;
         out_data <= '0;
         out_addr <= '0;
         last <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start && !abort && in_range) begin
               out_addr <= start_addr;
               out_data <= words[start_addr];
               out_valid <= 1'b1;
               last <= last_addr;
               state <= SEND;
            end
         end else if (abort) begin
            // abort beats a simultaneous handshake: that word is not delivered
            out_valid <= 1'b0;
            state <= IDLE;
         end else if (out_ready) begin
            if (out_addr == last) begin
               out_valid <= 1'b0;
               done <= 1'b1;
               state <= IDLE;
            end else begin
               out_addr <= next;
               out_data <= words[next];
            end
         end
      end
   end
endmodule

// File: tb/tb_register_bank_dump_reader.sv
// tb_register_bank_dump_reader: directed table, corner sequences and random traffic against a queue model
module tb_register_bank_dump_reader;
   localparam int DW = 32;
   localparam int Q = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic [DW-1:0] bank [Q];
   logic [Q*DW-1:0] bank_q;
   logic start, abort, out_ready;
   logic [AW-1:0] start_addr, last_addr;
   logic out_valid, busy, done;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_addr;

   logic start24, ready24, v24, busy24, done24;
   logic [4:0] sa24, la24, a24;
   logic [DW-1:0] d24;
   logic [24*DW-1:0] bank_q24;

   always_comb begin
      bank_q = '0;
      for (int i = 0; i < Q; i++) bank_q[DW*i +: DW] = bank[i];
   end
   assign bank_q24 = bank_q[24*DW-1:0];

   register_bank_dump_reader #(.DATA_LENGTH(DW), .REGS_QTY(Q)) dut (
      .clk(clk), .rst(rst), .bank_q(bank_q), .start(start), .start_addr(start_addr),
      .last_addr(last_addr), .abort(abort), .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done));

   register_bank_dump_reader #(.DATA_LENGTH(DW), .REGS_QTY(24)) dut24 (
      .clk(clk), .rst(rst), .bank_q(bank_q24), .start(start24), .start_addr(sa24),
      .last_addr(la24), .abort(1'b0), .out_ready(ready24), .out_valid(v24),
      .out_data(d24), .out_addr(a24), .busy(busy24), .done(done24));

   int errors = 0;
   int checks = 0;

   // Transaction-level model: the dump is a queue of addresses still to be sent
   bit m_valid, m_busy, m_done;
   int m_addr;
   logic [DW-1:0] m_data;
   int mq[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic mreset();
      m_valid = 0; m_busy = 0; m_done = 0; m_addr = 0; m_data = '0; mq.delete();
   endtask

   task automatic mstep();
      int s, l, n;
      m_done = 0;
      if (!m_busy) begin
         if (start && !abort) begin
            s = start_addr;
            l = last_addr;
            n = (l >= s) ? l - s + 1 : Q - s + l + 1;
            mq.delete();
            for (int k = 0; k < n; k++) mq.push_back((s + k) % Q);
            m_addr = mq.pop_front();
            m_data = bank[m_addr];
            m_valid = 1;
            m_busy = 1;
         end
      end else if (abort) begin
         m_valid = 0; m_busy = 0; mq.delete();
      end else if (out_ready) begin
         if (mq.size() == 0) begin
            m_valid = 0; m_done = 1; m_busy = 0;
         end else begin
            m_addr = mq.pop_front();
            m_data = bank[m_addr];
         end
      end
   endtask

   task automatic cyc();
      mstep();
      @(posedge clk);
      #1;
      chk("valid", out_valid, m_valid);
      chk("addr", out_addr, m_addr);
      chk("data", out_data, m_data);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
   endtask

   task automatic bank_reset();
      for (int i = 0; i < Q; i++) bank[i] = '0;
      bank[2] = 32'h1001_0140;
      bank[3] = 32'h1000_8000;
   endtask

   typedef struct {int sa; int la; int words;} vec_t;
   vec_t tbl[6];

   initial begin
      int cnt, nw;
      int exp24[4];
      tbl[0] = '{0, 31, 32};
      tbl[1] = '{30, 1, 4};
      tbl[2] = '{5, 5, 1};
      tbl[3] = '{2, 3, 2};
      tbl[4] = '{31, 0, 2};
      tbl[5] = '{10, 9, 32};
      exp24 = '{22, 23, 0, 1};
      rst = 0; start = 0; abort = 0; out_ready = 0; start_addr = '0; last_addr = '0;
      start24 = 0; ready24 = 0; sa24 = '0; la24 = '0;
      bank_reset();
      mreset();
      @(posedge clk); @(posedge clk); #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      rst = 1;
      cyc();

      // Directed table: ready held high, word count and done latency
      for (int t = 0; t < 6; t++) begin
         start = 1; start_addr = AW'(tbl[t].sa); last_addr = AW'(tbl[t].la); out_ready = 1;
         cyc();
         start = 0;
         cnt = 1;
         nw = out_valid ? 1 : 0;
         while (!done && cnt < 40) begin
            cyc();
            cnt++;
            if (out_valid) nw++;
         end
         chk("tbl_words", nw, tbl[t].words);
         chk("tbl_done_cycle", cnt, tbl[t].words + 1);
         cyc();
      end

      // Reset mid-dump clears everything immediately, no done afterwards
      start = 1; start_addr = 0; last_addr = 31; out_ready = 1;
      cyc();
      start = 0;
      cyc(); cyc();
      rst = 0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_addr", out_addr, 0);
      chk("arst_data", out_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      mreset();
      @(posedge clk); #1;
      rst = 1;
      cyc(); cyc();

      // Backpressure: held word ignores bank writes, next word reads the live bank
      start = 1; start_addr = 2; last_addr = 3; out_ready = 0;
      cyc();
      start = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) bank[2] = 32'hDEAD_BEEF;
         cyc();
      end
      chk("bp_hold", out_data, 32'h1001_0140);
      bank[3] = 32'h1234_5678;
      out_ready = 1;
      cyc();
      chk("bp_live", out_data, 32'h1234_5678);
      cyc();
      bank_reset();

      // Single word, with a new start accepted in the done cycle
      start = 1; start_addr = 5; last_addr = 5;
      cyc();
      start = 0;
      cyc();
      chk("single_done", done, 1);
      start = 1; start_addr = 7; last_addr = 7;
      cyc();
      start = 0;
      chk("restart_addr", out_addr, 7);
      cyc(); cyc();

      // Abort at the 4th word beats the handshake
      start = 1; start_addr = 0; last_addr = 31;
      cyc();
      start = 0;
      cyc(); cyc(); cyc();
      chk("abort_pre", out_addr, 3);
      abort = 1;
      cyc();
      abort = 0;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      cyc();
      chk("abort_nodone", done, 0);

      // Start with abort in IDLE does nothing
      start = 1; abort = 1; start_addr = 4; last_addr = 8;
      cyc();
      start = 0; abort = 0;
      chk("start_abort", busy, 0);
      cyc();

      // Start while busy is ignored
      start = 1; start_addr = 30; last_addr = 1;
      cyc();
      start_addr = 0; last_addr = 31;
      cnt = 0;
      while (!done && cnt < 10) begin
         cyc();
         cnt++;
      end
      start = 0;
      chk("busy_start_len", cnt, 4);
      cyc();

      // REGS_QTY=24: out-of-range requests ignored, wrap at 23
      ready24 = 1;
      start24 = 1; sa24 = 25; la24 = 3;
      cyc();
      chk("q24_ign_sa", v24, 0);
      sa24 = 0; la24 = 25;
      cyc();
      chk("q24_ign_la", v24, 0);
      chk("q24_ign_busy", busy24, 0);
      sa24 = 22; la24 = 1;
      cyc();
      start24 = 0;
      for (int k = 0; k < 4; k++) begin
         chk("q24_valid", v24, 1);
         chk("q24_addr", a24, exp24[k]);
         chk("q24_data", d24, bank[exp24[k]]);
         cyc();
      end
      chk("q24_done", done24, 1);
      ready24 = 0;

      // Random traffic against the model
      for (int r = 0; r < 600; r++) begin
         start = ($urandom % 4) == 0;
         start_addr = AW'($urandom);
         last_addr = AW'($urandom);
         abort = ($urandom % 24) == 0;
         out_ready = ($urandom % 3) != 0;
         if (($urandom % 4) == 0) bank[$urandom % Q] = $urandom;
         cyc();
      end
      start = 0; abort = 0; out_ready = 1;
      cnt = 0;
      while (busy && cnt < 40) begin
         cyc();
         cnt++;
      end
      chk("drain", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
